// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: serializes same-address lane writes, highest lane wins.
// Optional conflict counter: define MEM_WRITE_ARB_CONFLICT_CNT_EN.
module mem_write_arbiter #(
   parameter int LANES      = 4,
   parameter int MEM_DEPTH  = 256,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int DATA_WIDTH = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 req_valid,
   output logic                                 req_ready,
   input  logic [LANES-1:0]                     req_mask,
   input  logic [LANES-1:0][ADDR_WIDTH-1:0]     req_addr,
   input  logic [LANES-1:0][DATA_WIDTH-1:0]     req_data,
   output logic [LANES-1:0]                     mem_write_en,
   output logic [LANES-1:0][ADDR_WIDTH-1:0]     mem_write_addr,
   output logic [LANES-1:0][DATA_WIDTH-1:0]     mem_write_data,
   output logic                                 busy,
   output logic                                 done
`ifdef MEM_WRITE_ARB_CONFLICT_CNT_EN
   ,
   output logic [15:0]                          conflict_cnt
`endif
);

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   state_t                           state;
   logic [LANES-1:0]                 pend;
   logic [LANES-1:0][ADDR_WIDTH-1:0] lat_addr;
   logic [LANES-1:0][DATA_WIDTH-1:0] lat_data;
   logic                             done_q;
   logic [LANES-1:0]                 grant;
   logic [LANES-1:0]                 rest;
   logic                             fire;

`ifdef MEM_WRITE_ARB_CONFLICT_CNT_EN
   logic                             first_q;
`endif

   assign fire = req_valid && (state == IDLE);

   // A lane waits while any lower pending lane targets the same word.
   always_comb begin
      grant = '0;
      for (int i = 0; i < LANES; i++) begin
         grant[i] = pend[i] && (state == ISSUE);
         for (int j = 0; j < i; j++) begin
            if (pend[j] && (lat_addr[j] == lat_addr[i]))
               grant[i] = 1'b0;
         end
      end
   end

   assign rest           = pend & ~grant;
   assign mem_write_en   = grant;
   assign mem_write_addr = lat_addr;
   assign mem_write_data = lat_data;
   assign req_ready      = (state == IDLE);
   assign busy           = (state == ISSUE);
   assign done           = done_q;

   always_ff @(posedge clk) begin
      if (fire) begin
         lat_addr <= req_addr;
         lat_data <= req_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         pend   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fire) begin
                  if (req_mask == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     pend  <= req_mask;
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               pend <= rest;
               if (rest == '0) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_WRITE_ARB_CONFLICT_CNT_EN
   // Every ISSUE cycle beyond the first one of a batch is a collision stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
         first_q      <= 1'b0;
      end else begin
         if (fire && (req_mask != '0))
            first_q <= 1'b1;
         else if (state == ISSUE)
            first_q <= 1'b0;
         if ((state == ISSUE) && !first_q && (conflict_cnt != 16'hFFFF))
            conflict_cnt <= conflict_cnt + 16'd1;
      end
   end
`endif

endmodule
